tone_sequencer: RTL

Beat-driven scheduler for the tone datapath. It steps a 5-bit tone index up or down one note per beat, and that index feeds the tone-to-frequency decoder and then the audio PWM generator. Direction, tempo, pause and restart are controlled by single-cycle command strikes from the keyboard front end. It replaces ad-hoc beat/direction logic with one synchronous, fully reset FSM in the system clock domain.

---
 rtl/tone_sequencer.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/tone_sequencer.sv
// ---------------------------------------------------------------------------
// tone_sequencer
//
// Beat-driven scheduler for the tone datapath. A 32-bit beat counter runs
// through one beat period; at each boundary the 5-bit tone index moves one
// note in the current direction. The index feeds the tone-to-frequency
// decoder and then the audio PWM generator. Single-cycle command strikes
// from the keyboard front end control direction, tempo, pause and restart.
//
// Parameters
//   BEAT_CYCLES : clock cycles per beat at slow tempo (even, >= 4)
//   TONE_MAX    : highest tone index, 1..31 (lowest index is 0)
//
// Ports
//   clk        in   1  system clock
//   rst        in   1  synchronous active-high reset
//   cmd_valid  in   1  command strobe, cmd sampled while high
//   cmd        in   3  1=DIR_UP 2=DIR_DOWN 3=TEMPO_TOGGLE 4=PAUSE_TOGGLE
//                      5=RESTART, other codes ignored
//   tone       out  5  current tone index
//   tone_chg   out  1  pulse in the cycle tone takes a new value
//   beat       out  1  pulse on each beat boundary
//   dir        out  1  1 = ascending, 0 = descending
//   fast       out  1  1 = fast tempo (half beat period)
//   paused     out  1  1 = sequencing halted
//
// Configuration macro
//   TONE_SEQ_BOUNCE_EN : when defined, a step past either end reverses the
//                        direction instead of saturating.
// ---------------------------------------------------------------------------
module tone_sequencer #(
  parameter int unsigned BEAT_CYCLES = 100_000_000,
  parameter int unsigned TONE_MAX    = 28
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [2:0] cmd,
  output logic [4:0] tone,
  output logic       tone_chg,
  output logic       beat,
  output logic       dir,
  output logic       fast,
  output logic       paused
);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_PAUSE = 1'b1
  } state_t;

  localparam logic [2:0]  CMD_DIR_UP    = 3'd1;
  localparam logic [2:0]  CMD_DIR_DOWN  = 3'd2;
  localparam logic [2:0]  CMD_TEMPO     = 3'd3;
  localparam logic [2:0]  CMD_PAUSE     = 3'd4;
  localparam logic [2:0]  CMD_RESTART   = 3'd5;

  // Terminal counts (P-1) for the two tempos.
  localparam logic [31:0] LP_LAST_SLOW  = 32'(BEAT_CYCLES - 1);
  localparam logic [31:0] LP_LAST_FAST  = 32'((BEAT_CYCLES / 2) - 1);
  localparam logic [4:0]  LP_TONE_MAX   = 5'(TONE_MAX);

  state_t      r_state;
  logic [31:0] r_cnt;
  logic [4:0]  r_tone;
  logic        r_tone_chg;
  logic        r_beat;
  logic        r_dir;
  logic        r_fast;

  state_t      w_state_nxt;
  logic [31:0] w_cnt_nxt;
  logic [4:0]  w_tone_nxt;
  logic        w_chg_nxt;
  logic        w_beat_nxt;
  logic        w_dir_nxt;
  logic        w_fast_nxt;
  logic        w_advance;
  logic [31:0] w_last;

  // Terminal count for the tempo currently in force.
  always_comb begin
    if (r_fast) begin
      w_last = LP_LAST_FAST;
    end else begin
      w_last = LP_LAST_SLOW;
    end
  end

  // Next-state logic: command decode, beat counter and tone step.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_tone_nxt  = r_tone;
    w_chg_nxt   = 1'b0;
    w_beat_nxt  = 1'b0;
    w_dir_nxt   = r_dir;
    w_fast_nxt  = r_fast;
    w_advance   = 1'b0;

    // RESTART, TEMPO_TOGGLE and PAUSE_TOGGLE each swallow a coinciding beat;
    // direction commands and idle cycles let the counter advance.
    if (cmd_valid) begin
      case (cmd)
        CMD_RESTART: begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = 32'd0;
          w_tone_nxt  = 5'd0;
          w_dir_nxt   = 1'b1;
          w_chg_nxt   = (r_tone != 5'd0);
        end
        CMD_TEMPO: begin
          w_fast_nxt  = ~r_fast;
          w_cnt_nxt   = 32'd0;
        end
        CMD_PAUSE: begin
          case (r_state)
            ST_RUN:   w_state_nxt = ST_PAUSE;
            ST_PAUSE: w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_RUN;
          endcase
        end
        CMD_DIR_UP: begin
          w_dir_nxt   = 1'b1;
          w_advance   = 1'b1;
        end
        CMD_DIR_DOWN: begin
          w_dir_nxt   = 1'b0;
          w_advance   = 1'b1;
        end
        default: begin
          w_advance   = 1'b1;
        end
      endcase
    end else begin
      w_advance = 1'b1;
    end

    if (w_advance && (r_state == ST_RUN)) begin
      // >= rather than == so a corrupted count still wraps within one beat.
      if (r_cnt >= w_last) begin
        w_cnt_nxt  = 32'd0;
        w_beat_nxt = 1'b1;
        // The step uses the direction as updated by a same-cycle DIR command.
        if (w_dir_nxt) begin
          if (r_tone < LP_TONE_MAX) begin
            w_tone_nxt = r_tone + 5'd1;
            w_chg_nxt  = 1'b1;
          end else begin
`ifdef TONE_SEQ_BOUNCE_EN
            w_tone_nxt = LP_TONE_MAX - 5'd1;
            w_dir_nxt  = 1'b0;
            w_chg_nxt  = 1'b1;
`else
            w_tone_nxt = r_tone;
            w_chg_nxt  = 1'b0;
`endif
          end
        end else begin
          if (r_tone > 5'd0) begin
            w_tone_nxt = r_tone - 5'd1;
            w_chg_nxt  = 1'b1;
          end else begin
`ifdef TONE_SEQ_BOUNCE_EN
            w_tone_nxt = 5'd1;
            w_dir_nxt  = 1'b1;
            w_chg_nxt  = 1'b1;
`else
            w_tone_nxt = r_tone;
            w_chg_nxt  = 1'b0;
`endif
          end
        end
      end else begin
        w_cnt_nxt = r_cnt + 32'd1;
      end
    end else begin
      // Paused or command-suppressed cycle: no beat this edge.
      w_beat_nxt = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_cnt      <= 32'd0;
      r_tone     <= 5'd0;
      r_tone_chg <= 1'b0;
      r_beat     <= 1'b0;
      r_dir      <= 1'b1;
      r_fast     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_tone     <= w_tone_nxt;
      r_tone_chg <= w_chg_nxt;
      r_beat     <= w_beat_nxt;
      r_dir      <= w_dir_nxt;
      r_fast     <= w_fast_nxt;
    end
  end

  assign tone     = r_tone;
  assign tone_chg = r_tone_chg;
  assign beat     = r_beat;
  assign dir      = r_dir;
  assign fast     = r_fast;
  assign paused   = (r_state == ST_PAUSE);

endmodule
